// File: rtl/channel_pkg.sv
// Shared definitions for the Parallel Channel "A" interface: responder tag states,
// status byte bits and the command codes the control unit treats specially.
package channel_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_IN,
        ST_CMD_WAIT,
        ST_STATUS_IN,
        ST_STATUS_ACK,
        ST_WR_REQ,
        ST_WR_ACK,
        ST_RD_REQ,
        ST_RD_ACK,
        ST_END_STATUS,
        ST_END_ACK
    } tag_state_t;

    localparam logic [7:0] STATUS_DE    = 8'h20;
    localparam logic [7:0] STATUS_CE    = 8'h10;
    localparam logic [7:0] STATUS_CE_DE = STATUS_CE | STATUS_DE;

    localparam logic [7:0] CMD_TEST_IO = 8'h00;
    localparam logic [7:0] CMD_NOP     = 8'h03;

    function automatic logic [7:0] initial_status(input logic [7:0] cmd);
        return (cmd == CMD_NOP) ? STATUS_CE_DE : 8'h00;
    endfunction

endpackage

// File: rtl/parallel_control_unit.sv
// Device-side responder for Parallel Channel "A": answers selection, presents address,
// status and data on the in-tags, and moves commands/data over AXI-Stream.
module parallel_control_unit
    import channel_pkg::*;
#(
    parameter logic [7:0] DEVICE_ADDRESS = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a_bus_out,
    input  logic       a_operational_out,
    input  logic       a_hold_out,
    input  logic       a_select_out,
    input  logic       a_address_out,
    input  logic       a_command_out,
    input  logic       a_service_out,
    input  logic       a_suppress_out,
    output logic [7:0] a_bus_in,
    output logic       a_operational_in,
    output logic       a_address_in,
    output logic       a_status_in,
    output logic       a_service_in,
    output logic       a_select_in,
    output logic       a_request_in,
    output logic       busy,
    output logic [7:0] cmd_tdata,
    output logic       cmd_tvalid,
    output logic [7:0] data_recv_tdata,
    output logic       data_recv_tvalid,
    input  logic       data_recv_tready,
    input  logic [7:0] data_send_tdata,
    input  logic       data_send_tvalid,
    input  logic       data_send_tlast,
    output logic       data_send_tready
);

    tag_state_t state, state_n;
    logic [7:0] rd_byte, rd_byte_n, cmd_n, bus_in_n, recv_data_n;
    logic       held, held_n, last, last_n;
    logic       op_in_n, addr_in_n, status_in_n, service_in_n, select_n;
    logic       cmd_tvalid_n, recv_valid_n, send_tready_n;

    logic unused;
    assign unused = &{1'b0, a_hold_out, a_suppress_out};
    assign a_request_in = 1'b0;

    always_comb begin
        state_n      = state;
        cmd_n        = cmd_tdata;
        rd_byte_n    = rd_byte;
        held_n       = held;
        last_n       = last;
        select_n     = 1'b0;
        cmd_tvalid_n = 1'b0;
        recv_data_n  = data_recv_tdata;
        recv_valid_n = data_recv_tvalid && !data_recv_tready;

        if (!a_operational_out) begin
            state_n = ST_IDLE;
            held_n  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (a_address_out && a_select_out && a_bus_out == DEVICE_ADDRESS)
                        state_n = ST_ADDR_IN;
                    else
                        select_n = a_select_out && a_address_out;
                end
                ST_ADDR_IN: begin
                    if (a_command_out) begin
                        cmd_n        = a_bus_out;
                        cmd_tvalid_n = 1'b1;
                        state_n      = ST_CMD_WAIT;
                    end
                end
                ST_CMD_WAIT:   if (!a_command_out) state_n = ST_STATUS_IN;
                ST_STATUS_IN:  if (a_service_out) state_n = ST_STATUS_ACK;
                ST_STATUS_ACK: begin
                    if (!a_service_out) begin
                        if (cmd_tdata == CMD_TEST_IO || initial_status(cmd_tdata) != 8'h00)
                            state_n = ST_IDLE;
                        else if (cmd_tdata[0])
                            state_n = ST_WR_REQ;
                        else
                            state_n = ST_RD_REQ;
                    end
                end
                // Service-out only counts once our service-in is up, so a pending byte is never overwritten
                ST_WR_REQ: begin
                    if (a_command_out) begin
                        state_n = ST_END_STATUS;
                    end else if (a_service_out && a_service_in) begin
                        recv_data_n  = a_bus_out;
                        recv_valid_n = 1'b1;
                        state_n      = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: if (!a_service_out) state_n = ST_WR_REQ;
                ST_RD_REQ: begin
                    if (a_command_out) begin
                        held_n  = 1'b0;
                        state_n = ST_END_STATUS;
                    end else if (a_service_out && held) begin
                        held_n  = 1'b0;
                        state_n = ST_RD_ACK;
                    end else if (!held && data_send_tready && data_send_tvalid) begin
                        held_n    = 1'b1;
                        rd_byte_n = data_send_tdata;
                        last_n    = data_send_tlast;
                    end
                end
                ST_RD_ACK:     if (!a_service_out) state_n = last ? ST_END_STATUS : ST_RD_REQ;
                ST_END_STATUS: if (a_status_in && a_service_out) state_n = ST_END_ACK;
                ST_END_ACK:    if (!a_service_out) state_n = ST_IDLE;
                default:       state_n = ST_IDLE;
            endcase
        end

        // Every tag is a function of the state being entered, which gives the one-clock response
        op_in_n       = (state_n != ST_IDLE);
        addr_in_n     = (state_n == ST_ADDR_IN);
        status_in_n   = (state_n == ST_STATUS_IN) ||
                        (state_n == ST_END_STATUS && ((state == ST_END_STATUS && a_status_in) || !a_command_out));
        service_in_n  = (state_n == ST_WR_REQ && !recv_valid_n) || (state_n == ST_RD_REQ && held_n);
        send_tready_n = (state_n == ST_RD_REQ) && !held_n;

        bus_in_n = '0;
        if (addr_in_n)
            bus_in_n = DEVICE_ADDRESS;
        else if (state_n == ST_STATUS_IN)
            bus_in_n = initial_status(cmd_n);
        else if (state_n == ST_END_STATUS && status_in_n)
            bus_in_n = STATUS_CE_DE;
        else if (state_n == ST_RD_REQ && held_n)
            bus_in_n = rd_byte_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            rd_byte          <= '0;
            held             <= 1'b0;
            last             <= 1'b0;
            a_bus_in         <= '0;
            a_operational_in <= 1'b0;
            a_address_in     <= 1'b0;
            a_status_in      <= 1'b0;
            a_service_in     <= 1'b0;
            a_select_in      <= 1'b0;
            busy             <= 1'b0;
            cmd_tdata        <= '0;
            cmd_tvalid       <= 1'b0;
            data_recv_tdata  <= '0;
            data_recv_tvalid <= 1'b0;
            data_send_tready <= 1'b0;
        end else begin
            state            <= state_n;
            rd_byte          <= rd_byte_n;
            held             <= held_n;
            last             <= last_n;
            a_bus_in         <= bus_in_n;
            a_operational_in <= op_in_n;
            a_address_in     <= addr_in_n;
            a_status_in      <= status_in_n;
            a_service_in     <= service_in_n;
            a_select_in      <= select_n;
            busy             <= op_in_n;
            cmd_tdata        <= cmd_n;
            cmd_tvalid       <= cmd_tvalid_n;
            data_recv_tdata  <= recv_data_n;
            data_recv_tvalid <= recv_valid_n;
            data_send_tready <= send_tready_n;
        end
    end

endmodule

// File: tb/tb_parallel_control_unit.sv
// Bench for parallel_control_unit: plays the channel initiator through directed
// selections and checks tags, status bytes and stream traffic against expected sequences.
module tb_parallel_control_unit;

    logic       clk, reset;
    logic [7:0] a_bus_out;
    logic       a_operational_out, a_hold_out, a_select_out, a_address_out;
    logic       a_command_out, a_service_out, a_suppress_out;
    logic [7:0] a_bus_in;
    logic       a_operational_in, a_address_in, a_status_in, a_service_in, a_select_in, a_request_in;
    logic       busy;
    logic [7:0] cmd_tdata;
    logic       cmd_tvalid;
    logic [7:0] data_recv_tdata;
    logic       data_recv_tvalid, data_recv_tready;
    logic [7:0] data_send_tdata;
    logic       data_send_tvalid, data_send_tlast, data_send_tready;

    parallel_control_unit #(.DEVICE_ADDRESS(8'h01)) dut (
        .clk(clk), .reset(reset),
        .a_bus_out(a_bus_out), .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
        .a_select_out(a_select_out), .a_address_out(a_address_out), .a_command_out(a_command_out),
        .a_service_out(a_service_out), .a_suppress_out(a_suppress_out),
        .a_bus_in(a_bus_in), .a_operational_in(a_operational_in), .a_address_in(a_address_in),
        .a_status_in(a_status_in), .a_service_in(a_service_in), .a_select_in(a_select_in),
        .a_request_in(a_request_in), .busy(busy),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
        .data_recv_tdata(data_recv_tdata), .data_recv_tvalid(data_recv_tvalid),
        .data_recv_tready(data_recv_tready),
        .data_send_tdata(data_send_tdata), .data_send_tvalid(data_send_tvalid),
        .data_send_tlast(data_send_tlast), .data_send_tready(data_send_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int svc_rises = 0;
    bit rd_mode = 1'b0;
    bit wr_mode = 1'b0;
    logic prev_status = 1'b0;
    logic prev_service = 1'b0;
    logic [7:0] exp_cmd[$], exp_status[$], exp_rd[$], exp_recv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=nothing", name, act);
    endtask

    // Channel-level model: rules that must hold every cycle plus ordered event expectations
    always @(negedge clk) begin
        if (!reset) begin
            chk("request_in_tied", a_request_in, 0);
            chk("busy_vs_operational", busy, a_operational_in);
            chk("single_in_tag", ($countones({a_address_in, a_status_in, a_service_in}) <= 1), 1);
            if (!a_address_in && !a_status_in && !a_service_in) chk("bus_in_idle", a_bus_in, 0);
            if (a_address_in) chk("address_echo", a_bus_in, 8'h01);
            if (a_operational_in) chk("select_in_quiet", a_select_in, 0);
            if (wr_mode && a_service_in) chk("wr_service_while_pending", data_recv_tvalid, 0);
            if (cmd_tvalid) begin
                if (exp_cmd.size() == 0) unexpected("cmd_stream", cmd_tdata);
                else chk("cmd_stream", cmd_tdata, exp_cmd.pop_front());
            end
            if (a_status_in && !prev_status) begin
                if (exp_status.size() == 0) unexpected("status_byte", a_bus_in);
                else chk("status_byte", a_bus_in, exp_status.pop_front());
            end
            if (a_service_in && !prev_service) begin
                svc_rises++;
                if (rd_mode) begin
                    if (exp_rd.size() == 0) unexpected("read_byte", a_bus_in);
                    else chk("read_byte", a_bus_in, exp_rd.pop_front());
                end
            end
            if (data_recv_tvalid && data_recv_tready) begin
                if (exp_recv.size() == 0) unexpected("recv_byte", data_recv_tdata);
                else chk("recv_byte", data_recv_tdata, exp_recv.pop_front());
            end
        end
        prev_status  <= a_status_in;
        prev_service <= a_service_in;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function logic sig(input int id);
        case (id)
            0:       return a_address_in;
            1:       return a_status_in;
            2:       return a_service_in;
            3:       return a_operational_in;
            default: return data_send_tready;
        endcase
    endfunction

    task automatic wait_sig(input int id, input logic val, input string name);
        int n = 0;
        while (sig(id) !== val && n < 100) begin
            tick();
            n++;
        end
        if (sig(id) !== val) chk(name, sig(id), val);
    endtask

    task automatic select_and_command(input logic [7:0] cmd, input logic [7:0] init_st);
        exp_cmd.push_back(cmd);
        exp_status.push_back(init_st);
        a_bus_out = 8'h01; a_address_out = 1'b1; a_select_out = 1'b1; a_hold_out = 1'b1;
        tick();
        wait_sig(0, 1'b1, "address_in_timeout");
        a_address_out = 1'b0; a_bus_out = cmd; a_command_out = 1'b1;
        tick();
        chk("cmd_tvalid_latency", cmd_tvalid, 1);
        chk("cmd_tdata", cmd_tdata, cmd);
        chk("address_in_drop", a_address_in, 0);
        a_command_out = 1'b0; a_select_out = 1'b0; a_hold_out = 1'b0; a_bus_out = 8'h00;
        wait_sig(1, 1'b1, "status_in_timeout");
        a_service_out = 1'b1;
        wait_sig(1, 1'b0, "status_drop_timeout");
        a_service_out = 1'b0;
        tick();
    endtask

    task automatic ending_status;
        exp_status.push_back(8'h30);
        wait_sig(1, 1'b1, "end_status_timeout");
        a_service_out = 1'b1;
        wait_sig(1, 1'b0, "end_status_drop_timeout");
        a_service_out = 1'b0;
        tick();
        chk("idle_after_end_status", a_operational_in, 0);
    endtask

    task automatic feed_read;
        logic [7:0] bytes [3];
        bit hs;
        int n;
        bytes = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            data_send_tdata  = bytes[i];
            data_send_tlast  = (i == 2);
            data_send_tvalid = 1'b1;
            hs = 1'b0;
            n = 0;
            while (!hs && n < 200) begin
                @(negedge clk);
                hs = data_send_tready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!hs) chk("send_handshake_timeout", 0, 1);
        end
        data_send_tvalid = 1'b0;
        data_send_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int s;
        reset = 1'b1;
        a_bus_out = '0; a_operational_out = 1'b0; a_hold_out = 1'b0; a_select_out = 1'b0;
        a_address_out = 1'b0; a_command_out = 1'b0; a_service_out = 1'b0; a_suppress_out = 1'b0;
        data_recv_tready = 1'b1; data_send_tdata = '0; data_send_tvalid = 1'b0; data_send_tlast = 1'b0;
        repeat (3) tick();
        chk("reset_tags", {a_bus_in, a_operational_in, a_address_in, a_status_in, a_service_in,
                           a_select_in, a_request_in, busy}, 0);
        chk("reset_streams", {cmd_tdata, cmd_tvalid, data_recv_tdata, data_recv_tvalid, data_send_tready}, 0);
        reset = 1'b0; a_operational_out = 1'b1;
        tick();

        // Foreign address: select passes through, unit stays off the channel
        a_bus_out = 8'h05; a_address_out = 1'b1; a_select_out = 1'b1;
        tick();
        chk("select_propagated", a_select_in, 1);
        chk("foreign_not_operational", a_operational_in, 0);
        a_select_out = 1'b0;
        tick();
        chk("select_released", a_select_in, 0);
        a_address_out = 1'b0; a_bus_out = 8'h00;
        tick();

        select_and_command(8'h00, 8'h00);
        chk("test_io_idle", a_operational_in, 0);

        s = svc_rises;
        select_and_command(8'h03, 8'h30);
        chk("nop_idle", a_operational_in, 0);
        chk("nop_no_service", svc_rises - s, 0);

        // Write: A5, 5A (receiver stalls on the second), then stop on the third service_in
        wr_mode = 1'b1;
        exp_recv.push_back(8'hA5);
        exp_recv.push_back(8'h5A);
        select_and_command(8'h01, 8'h00);
        for (int i = 0; i < 2; i++) begin
            wait_sig(2, 1'b1, "wr_service_timeout");
            if (i == 1) begin
                data_recv_tready = 1'b0;
                fork
                    begin
                        repeat (8) @(posedge clk);
                        #1 data_recv_tready = 1'b1;
                    end
                join_none
            end
            a_bus_out = (i == 0) ? 8'hA5 : 8'h5A;
            a_service_out = 1'b1;
            wait_sig(2, 1'b0, "wr_service_drop_timeout");
            a_service_out = 1'b0; a_bus_out = 8'h00;
        end
        wait_sig(2, 1'b1, "wr_third_service_timeout");
        a_command_out = 1'b1;
        tick();
        chk("stop_drops_service", a_service_in, 0);
        chk("stop_status_waits", a_status_in, 0);
        a_command_out = 1'b0;
        ending_status();
        wr_mode = 1'b0;

        // Read: 11, 22, 33 with tlast on 33
        rd_mode = 1'b1;
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33);
        fork
            feed_read();
        join_none
        select_and_command(8'h02, 8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_sig(2, 1'b1, "rd_service_timeout");
            a_service_out = 1'b1;
            wait_sig(2, 1'b0, "rd_service_drop_timeout");
            a_service_out = 1'b0;
        end
        ending_status();

        // Operational-out dropped while waiting for read data
        select_and_command(8'h02, 8'h00);
        wait_sig(4, 1'b1, "rd_ready_timeout");
        a_operational_out = 1'b0;
        tick();
        chk("opdrop_tags", {a_bus_in, a_operational_in, a_address_in, a_status_in, a_service_in, a_select_in}, 0);
        chk("opdrop_busy", busy, 0);
        chk("opdrop_tready", data_send_tready, 0);
        a_operational_out = 1'b1;
        repeat (3) tick();
        rd_mode = 1'b0;

        chk("cmd_queue_drained", exp_cmd.size(), 0);
        chk("status_queue_drained", exp_status.size(), 0);
        chk("read_queue_drained", exp_rd.size(), 0);
        chk("recv_queue_drained", exp_recv.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
